// File: rtl/bus_slave_pkg.sv
// Shared types and helpers for the serial-bus memory slave.
package bus_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WCOMMIT,
    ST_RFETCH,
    ST_RDATA
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // Bits needed to index `depth` entries (at least one).
  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// Synchronous single-port RAM, one-cycle read latency, contents not reset.
module bus_slave_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned IDX_W      = bus_slave_pkg::idx_width(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Serial-bus memory slave: bit-serial address/burst/data in, burst RAM access, bit-serial read data out.
// Optional range checking with sticky err is enabled by defining BUS_SLAVE_ADDR_CHECK_EN.
module bus_slave_mem
  import bus_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter int unsigned BURST_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  output logic slave_ready,
  output logic slave_valid,
  input  logic rx_addr,
  input  logic rx_burst,
  input  logic rx_data,
  output logic tx_data,
  output logic busy,
  output logic err
);

  localparam int unsigned IDX_W = idx_width(MEM_DEPTH);
  localparam int unsigned CNT_W =
    idx_width(((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1);

  state_t                 state_q, state_d;
  op_t                    op_q, op_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic                   err_d;
  logic                   ram_we_c;
  logic [IDX_W-1:0]       ram_addr_c;
  logic [DATA_WIDTH-1:0]  ram_rdata;
  logic                   addr_oor_c;

`ifdef BUS_SLAVE_ADDR_CHECK_EN
  assign addr_oor_c = (64'(addr_q) >= 64'(MEM_DEPTH));
`else
  assign addr_oor_c = 1'b0;
`endif

  assign tx_data = shreg_q[0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, datapath updates and RAM controls
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    shreg_d  = shreg_q;
    err_d    = err;
    ram_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (master_valid && (read_en ^ write_en)) begin
          op_d    = write_en ? OP_WR : OP_RD;
          cnt_d   = '0;
          burst_d = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (master_valid) begin
          addr_d = ADDR_WIDTH'({rx_addr, addr_q} >> 1);
          if (cnt_q < CNT_W'(BURST_WIDTH))
            burst_d = BURST_WIDTH'({rx_burst, burst_q} >> 1);
          if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = (op_q == OP_WR) ? ST_WDATA : ST_RFETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WDATA: begin
        if (master_valid) begin
          wdata_d = DATA_WIDTH'({rx_data, wdata_q} >> 1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = ST_WCOMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WCOMMIT: begin
        ram_we_c = !addr_oor_c;
        if (addr_oor_c) err_d = 1'b1;
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (burst_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          burst_d = burst_q - BURST_WIDTH'(1);
          state_d = ST_WDATA;
        end
      end
      ST_RFETCH: begin
        shreg_d = addr_oor_c ? '1 : ram_rdata;
        if (addr_oor_c) err_d = 1'b1;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (master_ready) begin
          shreg_d = shreg_q >> 1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d  = '0;
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (burst_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              burst_d = burst_q - BURST_WIDTH'(1);
              state_d = ST_RFETCH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reads are issued with the upcoming address so the word is ready during RFETCH.
    ram_addr_c = (state_q == ST_WCOMMIT) ? IDX_W'(addr_q) : IDX_W'(addr_d);
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_RD;
      addr_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      shreg_q     <= '0;
      err         <= 1'b0;
      slave_ready <= 1'b1;
      slave_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      shreg_q     <= shreg_d;
      err         <= err_d;
      slave_ready <= (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_WDATA);
      slave_valid <= (state_d == ST_RDATA);
      busy        <= (state_d != ST_IDLE);
    end
  end

  bus_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem against an array-based memory model (MEM_DEPTH=2048).
module tb_bus_slave_mem;

  localparam int unsigned DEPTH = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic read_en = 1'b0, write_en = 1'b0;
  logic master_valid = 1'b0, master_ready = 1'b0;
  logic rx_addr = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
  logic slave_ready, slave_valid, tx_data, busy, err;

  always #5 clk = ~clk;

  bus_slave_mem #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (8),
    .MEM_DEPTH   (DEPTH),
    .BURST_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_en      (read_en),
    .write_en     (write_en),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .rx_addr      (rx_addr),
    .rx_burst     (rx_burst),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .busy         (busy),
    .err          (err)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] mem_m [DEPTH];
  logic       err_m = 1'b0;
  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [11:0] a);
`ifdef BUS_SLAVE_ADDR_CHECK_EN
    return int'(a) >= int'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_wr(input logic [11:0] a, input logic [7:0] d);
    if (out_of_range(a)) err_m = 1'b1;
    else mem_m[int'(a) % int'(DEPTH)] = d;
  endtask

  task automatic model_rd(input logic [11:0] a, output logic [7:0] d);
    if (out_of_range(a)) begin
      err_m = 1'b1;
      d = 8'hFF;
    end else begin
      d = mem_m[int'(a) % int'(DEPTH)];
    end
  endtask

  // One transaction at bit level. vmode: 0 valid held, 1 toggling, 2 random. rmode: 0 ready held, 1 random, 2 low cycles 16..20.
  task automatic xfer(input bit is_wr, input logic [11:0] a, input int nb, input int vmode,
                      input int rmode, output int cyc, output int first_v, output int gaps);
    logic [3:0] bf;
    logic [7:0] sh;
    int total_bits, idx, got_bits, beat;
    bit mv, mr;
    bf = 4'(nb - 1);
    total_bits = 12 + (is_wr ? nb * 8 : 0);
    idx = 0; cyc = 0; first_v = -1; gaps = 0; got_bits = 0; beat = 0; sh = '0;
    read_en = !is_wr; write_en = is_wr; master_valid = 1'b1; master_ready = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!busy) break;
      read_en  = 1'($urandom);
      write_en = 1'($urandom);
      mv = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) : 1'($urandom);
      if (idx >= total_bits) mv = 1'b0;
      master_valid = mv;
      rx_addr  = (idx < 12) ? a[idx] : 1'($urandom);
      rx_burst = (idx < 4) ? bf[idx] : 1'($urandom);
      rx_data  = (idx >= 12 && idx < total_bits) ? wbuf[(idx - 12) / 8][(idx - 12) % 8] : 1'($urandom);
      if (mv && slave_ready) idx++;
      mr = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : !(cyc >= 16 && cyc < 21);
      master_ready = mr;
      if (slave_valid) begin
        if (first_v < 0) first_v = cyc;
        if (mr) begin
          sh = {tx_data, sh[7:1]};
          got_bits++;
          if (got_bits % 8 == 0 && beat < 16) begin
            rbuf[beat] = sh;
            beat++;
          end
        end
      end else if (first_v >= 0) begin
        gaps++;
      end
    end
    read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
    chk("idle_after_xfer", 32'(busy), 32'd0);
    chk("bits_consumed", 32'(idx), 32'(total_bits));
    if (!is_wr) chk("bits_returned", 32'(got_bits), 32'(nb * 8));
  endtask

  task automatic do_wr(input logic [11:0] a, input int nb, input int vmode);
    int cyc, fv, gaps;
    xfer(1'b1, a, nb, vmode, 0, cyc, fv, gaps);
    for (int i = 0; i < nb; i++) model_wr(a + 12'(i), wbuf[i]);
    if (vmode == 0) chk("wr_latency", 32'(cyc), 32'(13 + nb * 9));
    chk("wr_err", 32'(err), 32'(err_m));
  endtask

  task automatic do_rd(input logic [11:0] a, input int nb, input int vmode, input int rmode);
    int cyc, fv, gaps;
    logic [7:0] exp_d;
    xfer(1'b0, a, nb, vmode, rmode, cyc, fv, gaps);
    for (int i = 0; i < nb; i++) begin
      model_rd(a + 12'(i), exp_d);
      chk($sformatf("rd_beat@%03h", a + 12'(i)), 32'(rbuf[i]), 32'(exp_d));
    end
    chk("rd_valid_gaps", 32'(gaps), 32'(nb - 1));
    if (vmode == 0 && rmode == 0) begin
      chk("rd_latency", 32'(cyc), 32'(13 + nb * 9));
      chk("rd_first_valid", 32'(fv), 32'd14);
    end
    chk("rd_err", 32'(err), 32'(err_m));
  endtask

  initial begin
    logic [11:0] ra;
    int nb;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_slave_ready", 32'(slave_ready), 32'd1);
    chk("rst_slave_valid", 32'(slave_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single write then read
    wbuf[0] = 8'hA5;
    do_wr(12'h010, 1, 0);
    do_rd(12'h010, 1, 0, 0);

    // 4-beat burst
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_wr(12'h0FE, 4, 0);
    do_rd(12'h0FE, 4, 0, 0);

    // Burst wrapping through all-ones
    wbuf[0] = 8'h5E; wbuf[1] = 8'hC3;
    do_wr(12'hFFF, 2, 0);
    do_rd(12'hFFF, 1, 0, 0);
    do_rd(12'h000, 1, 0, 0);

    // Stalls on both directions
    for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
    do_wr(12'h345, 3, 1);
    do_rd(12'h345, 3, 0, 2);
    do_rd(12'h345, 3, 2, 1);

    // Both enables high: ignored
    read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("both_en_busy", 32'(busy), 32'd0);
    end
    read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
    @(negedge clk);

    // Reset during the third data bit of a write to 0x010
    ra = 12'h010;
    write_en = 1'b1; master_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      write_en = 1'b0;
      rx_addr  = (k < 12) ? ra[k] : 1'b0;
      rx_burst = 1'b0;
      rx_data  = 1'b1;
    end
    @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("reset_abort_busy", 32'(busy), 32'd0);
    chk("reset_abort_ready", 32'(slave_ready), 32'd1);
    master_valid = 1'b0;
    err_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", 32'(busy), 32'd0);
    do_rd(12'h010, 1, 0, 0);

    // Out-of-range / aliasing above MEM_DEPTH
    wbuf[0] = 8'h3C;
    do_wr(12'h100, 1, 0);
    wbuf[0] = 8'h5A;
    do_wr(12'h900, 1, 0);
    do_rd(12'h100, 1, 0, 0);
    do_rd(12'h900, 1, 0, 0);

    // Randomized bursts
    for (int t = 0; t < 8; t++) begin
      ra = 12'($urandom);
      nb = 1 + int'($urandom_range(3));
      for (int i = 0; i < nb; i++) wbuf[i] = 8'($urandom);
      do_wr(ra, nb, int'($urandom_range(2)));
      do_rd(ra, nb, int'($urandom_range(2)), int'($urandom_range(2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
